// File: rtl/riscalar_reorder_buffer.sv
// Purpose: 8-entry in-order reorder buffer. It allocates at the tail, completes entries from the CDB,
//          commits in order at the head, and flushes everything on a mispredicted branch commit.
// Ports:   clk_in/rst_in (async active-high); alloc_* / ready_out / alloc_idx_out (issue side);
//          cdb_* (result broadcast); we_out/wa_out/wd_out/rob_ix_out (registered commit write);
//          flush_out/flush_addrs_out (registered squash report).
// Config:  define ROB_CDB_COMMIT_BYPASS_EN to let a CDB write to the head commit on the same edge.
module riscalar_reorder_buffer (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               alloc_valid_in,
    input  logic               alloc_has_rd_in,
    input  logic [4:0]         alloc_rd_in,
    input  logic               alloc_is_branch_in,
    output logic               ready_out,
    output logic [2:0]         alloc_idx_out,
    input  logic               cdb_valid_in,
    input  logic [2:0]         cdb_rob_idx_in,
    input  logic signed [31:0] cdb_data_in,
    input  logic               cdb_mispredict_in,
    output logic               we_out,
    output logic [4:0]         wa_out,
    output logic signed [31:0] wd_out,
    output logic [2:0]         rob_ix_out,
    output logic               flush_out,
    output logic [4:0]         flush_addrs_out [7:0]
);

    typedef struct packed {
        logic               valid;
        logic               done;
        logic               has_rd;
        logic [4:0]         rd;
        logic               is_branch;
        logic               mispredict;
        logic signed [31:0] data;
    } rob_entry_t;

    rob_entry_t         ent_q [8];
    rob_entry_t         ent_d [8];
    logic [2:0]         head_q, head_d, tail_q, tail_d;
    logic [3:0]         count_q, count_d;
    logic               we_q, we_d, flush_q, flush_d;
    logic [4:0]         wa_q, wa_d;
    logic signed [31:0] wd_q, wd_d;
    logic [2:0]         ix_q, ix_d;
    logic [4:0]         faddr_q [8];
    logic [4:0]         faddr_d [8];

    logic               alloc_fire, cdb_hit, commit, c_has_rd, c_mis;
    logic [4:0]         c_rd;
    logic signed [31:0] c_data;

    assign ready_out     = (count_q < 4'd8);
    assign alloc_idx_out = tail_q;
    assign we_out        = we_q;
    assign wa_out        = wa_q;
    assign wd_out        = wd_q;
    assign rob_ix_out    = ix_q;
    assign flush_out     = flush_q;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            flush_addrs_out[7 - i] = faddr_q[7 - i];
        end
    end

    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        we_d    = 1'b0;
        flush_d = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        ix_d    = ix_q;
        faddr_d = faddr_q;

        alloc_fire = alloc_valid_in && ready_out;
        // Late or duplicate broadcasts (free slot, already done) are dropped here.
        cdb_hit    = cdb_valid_in && ent_q[cdb_rob_idx_in].valid && !ent_q[cdb_rob_idx_in].done;

        commit   = ent_q[head_q].valid && ent_q[head_q].done;
        c_has_rd = ent_q[head_q].has_rd;
        c_rd     = ent_q[head_q].rd;
        c_data   = ent_q[head_q].data;
        c_mis    = ent_q[head_q].mispredict;
`ifdef ROB_CDB_COMMIT_BYPASS_EN
        // The head is not done yet, so a hit on it is the only way it can retire this edge.
        if (!commit && cdb_hit && (cdb_rob_idx_in == head_q)) begin
            commit = 1'b1;
            c_data = cdb_data_in;
            c_mis  = ent_q[head_q].is_branch && cdb_mispredict_in;
        end
`endif

        if (cdb_hit) begin
            ent_d[cdb_rob_idx_in].done       = 1'b1;
            ent_d[cdb_rob_idx_in].data       = cdb_data_in;
            ent_d[cdb_rob_idx_in].mispredict = ent_q[cdb_rob_idx_in].is_branch && cdb_mispredict_in;
        end

        // The head and tail coincide only when empty (no commit) or full (no alloc), so these never collide.
        if (commit) begin
            ent_d[head_q] = '0;
            head_d        = head_q + 3'd1;
            we_d          = c_has_rd;
            wa_d          = c_rd;
            wd_d          = c_data;
            ix_d          = head_q;
        end

        if (alloc_fire) begin
            ent_d[tail_q] = '{valid: 1'b1, done: 1'b0, has_rd: alloc_has_rd_in, rd: alloc_rd_in,
                              is_branch: alloc_is_branch_in, mispredict: 1'b0, data: '0};
            tail_d        = tail_q + 3'd1;
        end

        count_d = count_q + {3'b000, alloc_fire} - {3'b000, commit};

        // The mispredicted branch keeps its link write, but every other entry is squashed.
        // Any same-cycle allocation or CDB update is overridden by this clear.
        if (commit && c_mis) begin
            flush_d = 1'b1;
            for (int i = 0; i < 8; i++) begin
                faddr_d[i] = (ent_q[i].valid && ent_q[i].has_rd && (3'(i) != head_q)) ? ent_q[i].rd : 5'd0;
                ent_d[i]   = '0;
            end
            head_d  = 3'd0;
            tail_d  = 3'd0;
            count_d = 4'd0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 8; i++) begin
                ent_q[i]   <= '0;
                faddr_q[i] <= 5'd0;
            end
            head_q  <= 3'd0;
            tail_q  <= 3'd0;
            count_q <= 4'd0;
            we_q    <= 1'b0;
            flush_q <= 1'b0;
            wa_q    <= 5'd0;
            wd_q    <= 32'sd0;
            ix_q    <= 3'd0;
        end else begin
            ent_q   <= ent_d;
            faddr_q <= faddr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_q    <= we_d;
            flush_q <= flush_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            ix_q    <= ix_d;
        end
    end

endmodule

// File: tb/tb_riscalar_reorder_buffer.sv
// Purpose: self-checking bench for riscalar_reorder_buffer; expected commits are queued when
//          CDB stimulus is driven and popped when we_out/flush_out pulse.
// Ports:   none (top-level bench).
module tb_riscalar_reorder_buffer;

`ifdef ROB_CDB_COMMIT_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               alloc_valid_in, alloc_has_rd_in, alloc_is_branch_in;
    logic [4:0]         alloc_rd_in;
    logic               ready_out;
    logic [2:0]         alloc_idx_out;
    logic               cdb_valid_in, cdb_mispredict_in;
    logic [2:0]         cdb_rob_idx_in;
    logic signed [31:0] cdb_data_in;
    logic               we_out, flush_out;
    logic [4:0]         wa_out;
    logic signed [31:0] wd_out;
    logic [2:0]         rob_ix_out;
    logic [4:0]         flush_addrs_out [7:0];

    riscalar_reorder_buffer dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .alloc_valid_in     (alloc_valid_in),
        .alloc_has_rd_in    (alloc_has_rd_in),
        .alloc_rd_in        (alloc_rd_in),
        .alloc_is_branch_in (alloc_is_branch_in),
        .ready_out          (ready_out),
        .alloc_idx_out      (alloc_idx_out),
        .cdb_valid_in       (cdb_valid_in),
        .cdb_rob_idx_in     (cdb_rob_idx_in),
        .cdb_data_in        (cdb_data_in),
        .cdb_mispredict_in  (cdb_mispredict_in),
        .we_out             (we_out),
        .wa_out             (wa_out),
        .wd_out             (wd_out),
        .rob_ix_out         (rob_ix_out),
        .flush_out          (flush_out),
        .flush_addrs_out    (flush_addrs_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [2:0]  ix;
        logic        fl;
        int          cyc;
    } exp_t;

    exp_t sb [$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic push_exp(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                            input logic [2:0] ix, input logic fl, input int c);
        exp_t e;
        e.we = we; e.wa = wa; e.wd = wd; e.ix = ix; e.fl = fl; e.cyc = c;
        sb.push_back(e);
    endtask

    // Every commit/flush pulse must match the oldest outstanding expectation, on its cycle.
    always @(negedge clk_in) begin
        if (!rst_in && (we_out || flush_out)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {62'd0, we_out, flush_out}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("we",     we_out,              e.we);
                chk("flush",  flush_out,           e.fl);
                chk("wa",     wa_out,              e.wa);
                chk("wd",     $unsigned(wd_out),   e.wd);
                chk("rob_ix", rob_ix_out,          e.ix);
                chk("cycle",  cyc,                 e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic alloc(input logic has_rd, input logic [4:0] rd, input logic br);
        alloc_valid_in = 1'b1; alloc_has_rd_in = has_rd; alloc_rd_in = rd; alloc_is_branch_in = br;
        tick();
        alloc_valid_in = 1'b0;
    endtask

    task automatic cdb(input logic [2:0] idx, input logic [31:0] d, input logic mis);
        cdb_valid_in = 1'b1; cdb_rob_idx_in = idx; cdb_data_in = d; cdb_mispredict_in = mis;
        tick();
        cdb_valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        tick();
    endtask

    task automatic wait_sb(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            chk("sb_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (3) tick();
    endtask

    logic [39:0] fa;
    bit          seen;

    initial begin
        rst_in = 1'b1;
        alloc_valid_in = 0; alloc_has_rd_in = 0; alloc_rd_in = 0; alloc_is_branch_in = 0;
        cdb_valid_in = 0; cdb_rob_idx_in = 0; cdb_data_in = 0; cdb_mispredict_in = 0;
        repeat (2) @(posedge clk_in);
        #1;
        // Reset state
        chk("rst_ready", ready_out, 1);
        chk("rst_idx",   alloc_idx_out, 0);
        chk("rst_we",    we_out, 0);
        chk("rst_flush", flush_out, 0);
        chk("rst_wa",    wa_out, 0);
        chk("rst_wd",    $unsigned(wd_out), 0);
        chk("rst_ix",    rob_ix_out, 0);
        for (int i = 0; i < 8; i++) fa[i*5 +: 5] = flush_addrs_out[i];
        chk("rst_faddr", fa, 0);
        rst_in = 1'b0;
        tick();

        // Single commit and its latency
        alloc(1, 5'd5, 0);
        push_exp(1, 5'd5, 32'h1234, 3'd0, 0, cyc + LAT);
        cdb(3'd0, 32'h1234, 0);
        wait_sb(10);

        // Fill, full-with-commit refusal, wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            chk("fill_ready", ready_out, 1);
            chk("fill_idx",   alloc_idx_out, i);
            alloc(1, 5'(8 + i), 0);
        end
        chk("full_ready", ready_out, 0);
        push_exp(1, 5'd8, 32'hA0, 3'd0, 0, cyc + LAT);
        cdb_valid_in = 1; cdb_rob_idx_in = 0; cdb_data_in = 32'hA0; cdb_mispredict_in = 0;
        if (LAT == 1) begin
            alloc_valid_in = 1; alloc_has_rd_in = 1; alloc_rd_in = 5'd20; alloc_is_branch_in = 0;
        end
        tick();
        cdb_valid_in = 0;
        if (LAT == 2) begin
            chk("full_ready2", ready_out, 0);
            alloc_valid_in = 1; alloc_has_rd_in = 1; alloc_rd_in = 5'd20; alloc_is_branch_in = 0;
            tick();
        end
        alloc_valid_in = 0;
        chk("wrap_ready", ready_out, 1);
        chk("wrap_idx",   alloc_idx_out, 0);
        alloc(1, 5'd21, 0);
        chk("refull_ready", ready_out, 0);
        wait_sb(10);

        // Out-of-order completion, in-order commit
        do_reset();
        alloc(1, 5'd10, 0);
        alloc(1, 5'd11, 0);
        alloc(1, 5'd12, 0);
        cdb(3'd2, 32'h22, 0);
        cdb(3'd1, 32'h11, 0);
        repeat (4) tick();
        push_exp(1, 5'd10, 32'h10, 3'd0, 0, cyc + LAT);
        push_exp(1, 5'd11, 32'h11, 3'd1, 0, cyc + LAT + 1);
        push_exp(1, 5'd12, 32'h22, 3'd2, 0, cyc + LAT + 2);
        cdb(3'd0, 32'h10, 0);
        wait_sb(12);

        // Mispredict flush
        do_reset();
        alloc(1, 5'd1, 1);
        alloc(1, 5'd3, 0);
        alloc(1, 5'd7, 0);
        alloc(0, 5'd9, 0);
        push_exp(1, 5'd1, 32'h80, 3'd0, 1, cyc + LAT);
        cdb(3'd0, 32'h80, 1);
        seen = 0;
        for (int n = 0; n < 6 && !seen; n++) begin
            if (flush_out) begin
                seen = 1;
                for (int i = 0; i < 8; i++) fa[i*5 +: 5] = flush_addrs_out[i];
                chk("flush_addrs", fa, (40'd3 << 5) | (40'd7 << 10));
                chk("flush_ready", ready_out, 1);
                chk("flush_idx",   alloc_idx_out, 0);
            end else begin
                tick();
            end
        end
        chk("flush_seen", seen, 1);
        cdb(3'd1, 32'h5, 0);
        wait_sb(10);

        // Ignored CDB writes and non-branch mispredict
        do_reset();
        alloc(1, 5'd4, 0);
        cdb(3'd5, 32'h55, 0);
        alloc(1, 5'd6, 0);
        cdb(3'd1, 32'h11, 1);
        cdb(3'd1, 32'h22, 0);
        repeat (3) tick();
        push_exp(1, 5'd4, 32'h33, 3'd0, 0, cyc + LAT);
        push_exp(1, 5'd6, 32'h11, 3'd1, 0, cyc + LAT + 1);
        cdb(3'd0, 32'h33, 0);
        wait_sb(10);
        chk("empty_idx", alloc_idx_out, 2);

        // Mid-operation reset
        do_reset();
        alloc(1, 5'd14, 0);
        alloc(1, 5'd15, 0);
        alloc(1, 5'd16, 0);
        alloc(1, 5'd17, 0);
        push_exp(1, 5'd14, 32'h77, 3'd0, 0, cyc + LAT);
        cdb(3'd0, 32'h77, 0);
        cdb(3'd3, 32'h99, 0);
        wait_sb(10);
        chk("pre_rst_wa",  wa_out, 14);
        chk("pre_rst_idx", alloc_idx_out, 4);
        #3 rst_in = 1'b1;
        #1;
        chk("mid_rst_wa",    wa_out, 0);
        chk("mid_rst_wd",    $unsigned(wd_out), 0);
        chk("mid_rst_idx",   alloc_idx_out, 0);
        chk("mid_rst_ready", ready_out, 1);
        chk("mid_rst_we",    {we_out, flush_out}, 0);
        tick();
        rst_in = 1'b0;
        repeat (4) tick();
        cdb(3'd3, 32'h99, 0);
        cdb(3'd1, 32'h98, 0);
        repeat (6) tick();

        chk("sb_left", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
